adc_frame_aligner: RTL and testbench
====================================

# adc_frame_aligner

FCO-driven frame aligner and deserializer in the dco_clk domain. It sits directly downstream of the DDR lane capture stage. Each cycle it takes the rise/fall bit pair for every data lane and for the frame clock (FCO). It finds the frame boundary at single-bit granularity, qualifies lock over consecutive frames, and emits one parallel frame word per ADC frame toward the word-assembly/FIFO path.

## Interface
- LANES, 8: number of LVDS data lanes.
- FRAME_BITS, 16: serial bits per lane per frame; must be even and ≥4.
- MISS_LIMIT, 3: consecutive mismatched frames in LOCKED before returning to SEARCH.

- dco_clk  in  1  capture clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rise_bits  in  LANES  per-lane bit captured on the DCO rising edge (older bit of the pair).
- fall_bits  in  LANES  per-lane bit captured on the DCO falling edge (newer bit).
- fco_rise  in  1  FCO sampled on the rising edge.
- fco_fall  in  1  FCO sampled on the falling edge.
- lock_n  in  8  consecutive good frames required in VERIFY; 0 is treated as 1.
- realign  in  1  single-cycle pulse that forces SEARCH.
- frame_data  out  LANES*FRAME_BITS  lane L occupies [L*FRAME_BITS +: FRAME_BITS]; MSB is the oldest bit.
- frame_valid  out  1  one-cycle strobe marking frame_data as valid.
- locked  out  1  high while the state is LOCKED.
- bit_odd  out  1  selected bit offset within the pair (0 = even, 1 = odd).
- align_pulse  out  1  one-cycle pulse on entry to LOCKED.
- err_pulse  out  1  one-cycle pulse on each FCO mismatch while LOCKED.
- err_count  out  16  saturating count of LOCKED mismatches.

## Operation
- History registers:
  - Each cycle, every lane and FCO shifts a (FRAME_BITS+1)-bit register: hist <= {hist[FRAME_BITS-2:0], rise, fall}.
  - Even window = hist[FRAME_BITS-1:0]. Odd window = hist[FRAME_BITS:1].
- FCO match: the selected FCO window equals FRAME_BITS/2 ones followed by FRAME_BITS/2 zeros, MSB first (16'hFF00 for FRAME_BITS=16).
- Phase counter:
  - 0..FRAME_BITS/2-1; it loads 0 on detection and wraps.
  - A frame-end evaluation occurs when the counter equals FRAME_BITS/2-1.
- SEARCH:
  - The registered histories are checked every cycle.
  - If the even window matches, bit_odd=0; otherwise, if the odd window matches, bit_odd=1. Either way, phase=0, good_cnt=0, go to VERIFY. Even wins a tie.
- VERIFY (at each evaluation):
  - Match: good_cnt++. When good_cnt reaches max(lock_n,1), go to LOCKED and pulse align_pulse.
  - Mismatch: go to SEARCH.
  - No frames are emitted in this state.
- LOCKED (at each evaluation):
  - The selected window of every lane is registered into frame_data and frame_valid is pulsed.
  - Match clears miss_cnt.
  - Mismatch pulses err_pulse, increments err_count (saturating at 16'hFFFF) and increments miss_cnt. The frame is still emitted.
  - When miss_cnt reaches MISS_LIMIT, go to SEARCH. The frame that triggers the transition is not emitted.
- realign: any state goes to SEARCH on the next edge. An evaluation in the same cycle is suppressed (no frame_valid, err_pulse or align_pulse). err_count is not cleared.
- bit_odd changes only on SEARCH detection.

## Timing
- Reset: state SEARCH; histories, counters and every output are 0. An all-zero FCO history cannot match.
- Latency: frame_valid asserts 2 dco_clk cycles after the cycle whose rise/fall inputs carry the frame's last bit.
- Steady-state LOCKED: exactly one frame_valid every FRAME_BITS/2 cycles. frame_data holds its value between strobes.
- Locking: the first frame_valid is for the evaluation immediately after the one that entered LOCKED. For lock_n=N, align_pulse comes (N+1)·FRAME_BITS/2 cycles after detection.
- locked falls on the same edge that enters SEARCH.
- Reset asserted mid-frame: everything clears immediately. No partial frame is emitted after release.

## Configuration
- ADC_FRAME_ALIGN_ERRCNT_EN:
  - Defined: err_count is implemented as described.
  - Undefined: the err_count register is removed and the output is tied to 0.
  - err_pulse and miss handling are unaffected either way.

## Test plan
- Even alignment: FRAME_BITS=16, lock_n=4, FCO=0xFF00 on even boundary, lane L carries 16'hA500+L. Required: bit_odd=0; align_pulse after 5 frame ends; then frame_valid every 8 cycles with lane data 16'hA500+L.
- Odd alignment: same stimulus delayed by one bit. Required: bit_odd=1 and identical frame_data.
- Glitch tolerance: lock, then corrupt FCO in 2 consecutive frames (MISS_LIMIT=3). Required: 2 err_pulses, err_count=2, locked stays 1, the corrupted frames are still emitted. A third consecutive corruption drops locked, with no frame_valid for that frame.
- VERIFY failure: corrupt FCO in the 2nd frame after detection. Required: return to SEARCH, no align_pulse, no frame_valid.
- realign and reset: a realign pulse in LOCKED gives locked=0 next cycle and re-lock after lock_n+1 frames. rst_n asserted mid-frame clears all outputs to 0 immediately.
- lock_n=0: behaves as 1, with align_pulse at the second frame end after detection.

Source files
------------

// File: rtl/adc_frame_aligner.sv
// FCO-locked frame aligner and deserializer for DDR ADC lanes.
// Define ADC_FRAME_ALIGN_ERRCNT_EN to implement the err_count register.
module adc_frame_aligner #(
  parameter int LANES      = 8,
  parameter int FRAME_BITS = 16,
  parameter int MISS_LIMIT = 3
) (
  input  logic                        dco_clk,
  input  logic                        rst_n,
  input  logic [LANES-1:0]            rise_bits,
  input  logic [LANES-1:0]            fall_bits,
  input  logic                        fco_rise,
  input  logic                        fco_fall,
  input  logic [7:0]                  lock_n,
  input  logic                        realign,
  output logic [LANES*FRAME_BITS-1:0] frame_data,
  output logic                        frame_valid,
  output logic                        locked,
  output logic                        bit_odd,
  output logic                        align_pulse,
  output logic                        err_pulse,
  output logic [15:0]                 err_count
);

  localparam int HALF = FRAME_BITS / 2;
  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int MW = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT + 1) : 1;
  localparam logic [FRAME_BITS-1:0] FCO_PAT =
    {{HALF{1'b1}}, {HALF{1'b0}}};
  localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [FRAME_BITS:0]            fco_hist;
  logic [LANES-1:0][FRAME_BITS:0] lane_hist;
  logic [LANES*FRAME_BITS-1:0]    sel_data;
  logic [FRAME_BITS-1:0]          fco_win;

  logic [PW-1:0] phase, phase_nx;
  logic [7:0]    good_cnt, good_nx;
  logic [MW-1:0] miss_cnt, miss_nx;
  logic [7:0]    lock_eff;
  logic          odd_nx;
  logic          even_hit, odd_hit, fco_ok, eval;
  logic          emit, err, align;

  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      fco_hist  <= '0;
      lane_hist <= '0;
    end else begin
      fco_hist <= {fco_hist[FRAME_BITS-2:0], fco_rise, fco_fall};
      for (int l = 0; l < LANES; l++)
        lane_hist[l] <= {lane_hist[l][FRAME_BITS-2:0],
                         rise_bits[l], fall_bits[l]};
    end
  end

  // Odd alignment drops the newest bit, taking the window one bit older.
  always_comb begin
    sel_data = '0;
    for (int l = 0; l < LANES; l++)
      sel_data[l*FRAME_BITS +: FRAME_BITS] = bit_odd ?
        lane_hist[l][FRAME_BITS:1] : lane_hist[l][FRAME_BITS-1:0];
  end

  assign fco_win  = bit_odd ? fco_hist[FRAME_BITS:1]
                            : fco_hist[FRAME_BITS-1:0];
  assign even_hit = (fco_hist[FRAME_BITS-1:0] == FCO_PAT);
  assign odd_hit  = (fco_hist[FRAME_BITS:1] == FCO_PAT);
  assign fco_ok   = (fco_win == FCO_PAT);
  assign eval     = (phase == PH_LAST);
  assign lock_eff = (lock_n == 8'd0) ? 8'd1 : lock_n;
  assign locked   = (state == LOCKED);

  always_comb begin
    state_nx = state;
    phase_nx = eval ? '0 : phase + 1'b1;
    good_nx  = good_cnt;
    miss_nx  = miss_cnt;
    odd_nx   = bit_odd;
    emit     = 1'b0;
    err      = 1'b0;
    align    = 1'b0;
    if (realign) begin
      state_nx = SEARCH;
      phase_nx = '0;
      good_nx  = '0;
      miss_nx  = '0;
    end else begin
      unique case (state)
        SEARCH: begin
          phase_nx = '0;
          if (even_hit || odd_hit) begin
            odd_nx   = !even_hit;
            state_nx = VERIFY;
            good_nx  = '0;
            miss_nx  = '0;
          end
        end
        VERIFY: begin
          if (eval) begin
            if (!fco_ok) begin
              state_nx = SEARCH;
            end else if (good_cnt >= lock_eff) begin
              state_nx = LOCKED;
              align    = 1'b1;
              miss_nx  = '0;
            end else begin
              good_nx = good_cnt + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (eval) begin
            if (fco_ok) begin
              miss_nx = '0;
              emit    = 1'b1;
            end else begin
              err = 1'b1;
              if (miss_cnt >= MISS_LAST) begin
                state_nx = SEARCH;
                miss_nx  = '0;
              end else begin
                miss_nx = miss_cnt + 1'b1;
                emit    = 1'b1;
              end
            end
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      phase       <= '0;
      good_cnt    <= '0;
      miss_cnt    <= '0;
      bit_odd     <= 1'b0;
      frame_valid <= 1'b0;
      align_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      frame_data  <= '0;
    end else begin
      state       <= state_nx;
      phase       <= phase_nx;
      good_cnt    <= good_nx;
      miss_cnt    <= miss_nx;
      bit_odd     <= odd_nx;
      frame_valid <= emit;
      align_pulse <= align;
      err_pulse   <= err;
      if (emit)
        frame_data <= sel_data;
    end
  end

`ifdef ADC_FRAME_ALIGN_ERRCNT_EN
  logic [15:0] err_q;

  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= '0;
    else if (err && (err_q != 16'hFFFF))
      err_q <= err_q + 16'd1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Self-checking bench for adc_frame_aligner: serial streams built from
// frame words, expectations from a frame-level reference model.
module tb_adc_frame_aligner;

  localparam int LANES = 8;
  localparam int FB    = 16;
`ifdef ADC_FRAME_ALIGN_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic              dco_clk = 1'b0;
  logic              rst_n;
  logic [LANES-1:0]  rise_bits, fall_bits;
  logic              fco_rise, fco_fall;
  logic [7:0]        lock_n;
  logic              realign;
  logic [LANES*FB-1:0] frame_data;
  logic              frame_valid, locked, bit_odd;
  logic              align_pulse, err_pulse;
  logic [15:0]       err_count;

  logic [15:0] fco_w [64];
  logic [15:0] lane_w [64][LANES];

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 dco_clk = ~dco_clk;

  adc_frame_aligner #(
    .LANES(LANES), .FRAME_BITS(FB), .MISS_LIMIT(3)
  ) dut (
    .dco_clk(dco_clk), .rst_n(rst_n),
    .rise_bits(rise_bits), .fall_bits(fall_bits),
    .fco_rise(fco_rise), .fco_fall(fco_fall),
    .lock_n(lock_n), .realign(realign),
    .frame_data(frame_data), .frame_valid(frame_valid),
    .locked(locked), .bit_odd(bit_odd),
    .align_pulse(align_pulse), .err_pulse(err_pulse),
    .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  // Serial stream: p leading zero bits, then frame words MSB first.
  function automatic logic sbit(int p, int nf, int s, int lane);
    int f, k;
    if (s < p) return 1'b0;
    f = (s - p) / FB;
    k = (s - p) % FB;
    if (f >= nf) return 1'b0;
    if (lane < 0) return fco_w[f][FB-1-k];
    return lane_w[f][lane][FB-1-k];
  endfunction

  task automatic drive(input int p, input int nf, input int e);
    for (int l = 0; l < LANES; l++) begin
      rise_bits[l] = sbit(p, nf, 2*e, l);
      fall_bits[l] = sbit(p, nf, 2*e+1, l);
    end
    fco_rise = sbit(p, nf, 2*e, -1);
    fco_fall = sbit(p, nf, 2*e+1, -1);
  endtask

  task automatic chk_zero(input string ph);
    chk({ph, "_data"}, frame_data, 128'h0);
    chk({ph, "_valid"}, frame_valid, 1'b0);
    chk({ph, "_locked"}, locked, 1'b0);
    chk({ph, "_odd"}, bit_odd, 1'b0);
    chk({ph, "_align"}, align_pulse, 1'b0);
    chk({ph, "_err"}, err_pulse, 1'b0);
    chk({ph, "_errcnt"}, err_count, 16'h0);
  endtask

  function automatic void fill(int nf, bit rnd);
    for (int f = 0; f < nf; f++) begin
      fco_w[f] = 16'hFF00;
      for (int l = 0; l < LANES; l++)
        lane_w[f][l] = rnd ? 16'($urandom) : 16'hA500 + 16'(l);
    end
  endfunction

  // mode: 0 search, 1 verify, 2 locked
  task automatic run(input int p, input int nf, input int ln,
                     input int rl, input int rs);
    int mode, good, miss, neff, last, fi;
    logic ev_v, ev_a, ev_e, x_odd, ok;
    logic [15:0] x_err;
    logic [127:0] x_data;
    mode = 0; good = 0; miss = 0;
    x_odd = 1'b0; x_err = '0; x_data = '0;
    neff = (ln == 0) ? 1 : ln;
    rst_n = 1'b0; realign = 1'b0;
    rise_bits = '0; fall_bits = '0;
    fco_rise = 1'b0; fco_fall = 1'b0;
    lock_n = 8'(ln);
    repeat (2) @(negedge dco_clk);
    chk_zero("reset");
    rst_n = 1'b1;
    last = ((p + FB*(nf-1) + FB-1) >> 1) + 4;
    for (int e = 0; e <= last; e++) begin
      cyc = e;
      drive(p, nf, e);
      realign = (e == rl);
      if (e == rs) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(negedge dco_clk);
        @(negedge dco_clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
          drive(p, nf, e + k);
          @(posedge dco_clk);
          @(negedge dco_clk);
          chk("post_rst_valid", frame_valid, 1'b0);
          chk("post_rst_locked", locked, 1'b0);
        end
        return;
      end
      @(posedge dco_clk);
      ev_v = 1'b0; ev_a = 1'b0; ev_e = 1'b0;
      fi = -1;
      for (int f = 0; f < nf; f++)
        if (((p + FB*f + FB-1) >> 1) + 1 == e) fi = f;
      if (e == rl) begin
        mode = 0;
      end else if (fi >= 0) begin
        ok = (fco_w[fi] == 16'hFF00);
        case (mode)
          0: if (ok) begin
               mode = 1; good = 0; x_odd = (p % 2 == 1);
             end
          1: if (!ok) mode = 0;
             else if (good >= neff) begin
               mode = 2; ev_a = 1'b1; miss = 0;
             end else good++;
          default: begin
            if (ok) begin
              miss = 0; ev_v = 1'b1;
            end else begin
              ev_e = 1'b1;
              if (x_err != 16'hFFFF) x_err++;
              miss++;
              if (miss == 3) begin mode = 0; miss = 0; end
              else ev_v = 1'b1;
            end
          end
        endcase
        if (ev_v)
          for (int l = 0; l < LANES; l++)
            x_data[l*FB +: FB] = lane_w[fi][l];
      end
      @(negedge dco_clk);
      chk("frame_valid", frame_valid, ev_v);
      chk("align_pulse", align_pulse, ev_a);
      chk("err_pulse", err_pulse, ev_e);
      chk("locked", locked, mode == 2);
      chk("bit_odd", bit_odd, x_odd);
      chk("err_count", err_count, ERRCNT ? x_err : 16'h0);
      chk("frame_data", frame_data, x_data);
    end
    realign = 1'b0;
  endtask

  initial begin
    int n, p;
    // even alignment, fixed lane pattern
    fill(10, 1'b0);
    run(4, 10, 4, -1, -1);
    // odd alignment, same words one bit later
    run(5, 10, 4, -1, -1);
    // glitch tolerance then drop and relock
    n = $urandom_range(1, 3);
    fill(2*n + 16, 1'b1);
    fco_w[n+4] = 16'h0; fco_w[n+5] = 16'h0;
    fco_w[n+7] = 16'h0; fco_w[n+8] = 16'h0; fco_w[n+9] = 16'h0;
    run($urandom_range(0, 9), 2*n + 16, n, -1, -1);
    // verify failure on 2nd frame after detection
    fill(12, 1'b1);
    fco_w[2] = 16'h0;
    run($urandom_range(0, 9), 12, 3, -1, -1);
    // realign mid-frame while locked
    fill(14, 1'b1);
    p = $urandom_range(0, 9);
    run(p, 14, 1, ((p + FB*5 + FB-1) >> 1) + 1 - 3, -1);
    // realign coinciding with an evaluation
    fill(14, 1'b1);
    p = $urandom_range(0, 9);
    run(p, 14, 1, ((p + FB*4 + FB-1) >> 1) + 1, -1);
    // lock_n = 0 behaves as 1
    fill(8, 1'b1);
    run($urandom_range(0, 9), 8, 0, -1, -1);
    // random FCO corruption
    for (int r = 0; r < 3; r++) begin
      fill(20, 1'b1);
      for (int f = 0; f < 20; f++)
        if ($urandom_range(0, 4) == 0) fco_w[f] = 16'h0;
      run($urandom_range(0, 9), 20, $urandom_range(0, 3), -1, -1);
    end
    // reset mid-frame while locked
    fill(10, 1'b1);
    run(2, 10, 1, -1, ((2 + FB*5 + FB-1) >> 1) + 1 - 4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
